// File: rtl/vx_warp_commit_tracker.sv
// Per-warp in-flight instruction counters between issue and commit.
// Also generates commit pulses, pending-zero flags and a single-outstanding drain handshake.
module vx_warp_commit_tracker #(
    parameter  int NUM_WARPS   = 4,
    parameter  int NUM_COMMITS = 2,
    parameter  int CTR_WIDTH   = 5,
    localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [WID_W-1:0]             issue_wid,
    output logic                         issue_ready,
    input  logic [NUM_COMMITS-1:0]       commit_valid,
    input  logic [NUM_COMMITS*WID_W-1:0] commit_wid,
    output logic [NUM_WARPS-1:0]         committed_warps,
    output logic [NUM_WARPS-1:0]         pending_zero,
    input  logic                         drain_valid,
    input  logic [WID_W-1:0]             drain_wid,
    output logic                         drain_ready,
    output logic                         drain_done,
    output logic [WID_W-1:0]             drain_done_wid,
    output logic                         underflow_err
);

    localparam int SUM_W = CTR_WIDTH + 2;
    localparam logic [CTR_WIDTH-1:0] MAX_PENDING = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e                       state_q, state_d;
    logic [WID_W-1:0]             drain_wid_q, drain_wid_d;
    logic [CTR_WIDTH-1:0]         count_q [NUM_WARPS];
    logic [CTR_WIDTH-1:0]         count_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]         committed_q, committed_d;
    logic [NUM_WARPS-1:0]         pzero_q, pzero_d;
    logic                         underflow_q, underflow_d;
    logic [SUM_W-1:0]             dec_w [NUM_WARPS];
    logic signed [SUM_W-1:0]      sum_w [NUM_WARPS];
    logic                         issue_fire;

    function automatic logic signed [SUM_W-1:0] step_count(
        input logic [CTR_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic [SUM_W-1:0]     dec
    );
        return $signed({2'b00, cnt}) + $signed({{(SUM_W-1){1'b0}}, inc}) - $signed(dec);
    endfunction

    function automatic logic [CTR_WIDTH-1:0] clamp_count(input logic signed [SUM_W-1:0] s);
        return (s < 0) ? '0 : s[CTR_WIDTH-1:0];
    endfunction

    // Saturation is judged on the registered count only, so a same-cycle commit never frees a slot.
    assign issue_ready = (count_q[issue_wid] != MAX_PENDING) &&
                         !((state_q != S_IDLE) && (issue_wid == drain_wid_q));
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        underflow_d = underflow_q;
        committed_d = '0;
        pzero_d     = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            dec_w[w] = '0;
            for (int i = 0; i < NUM_COMMITS; i++) begin
                if (commit_valid[i] && (commit_wid[i*WID_W +: WID_W] == WID_W'(w))) begin
                    dec_w[w] = dec_w[w] + SUM_W'(1);
                end
            end
            sum_w[w] = step_count(count_q[w], issue_fire && (issue_wid == WID_W'(w)), dec_w[w]);
            if (sum_w[w] < 0) begin
                underflow_d = 1'b1;
            end
            count_d[w]     = clamp_count(sum_w[w]);
            committed_d[w] = (dec_w[w] != '0);
            pzero_d[w]     = (count_d[w] == '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_wid_d = drain_wid_q;
        case (state_q)
            S_IDLE: begin
                if (drain_valid) begin
                    drain_wid_d = drain_wid;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pzero_q[drain_wid_q]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_wid_q <= '0;
            committed_q <= '0;
            pzero_q     <= '1;
            underflow_q <= 1'b0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= '0;
            end
        end else begin
            state_q     <= state_d;
            drain_wid_q <= drain_wid_d;
            committed_q <= committed_d;
            pzero_q     <= pzero_d;
            underflow_q <= underflow_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= count_d[w];
            end
        end
    end

    assign drain_ready     = (state_q == S_IDLE) && !reset;
    assign drain_done      = (state_q == S_DONE);
    assign drain_done_wid  = (state_q == S_DONE) ? drain_wid_q : '0;
    assign committed_warps = committed_q;
    assign pending_zero    = pzero_q;
    assign underflow_err   = underflow_q;

endmodule

// File: doc/vx_warp_commit_tracker.md
# vx_warp_commit_tracker

Per-warp in-flight instruction tracker between the issue stage and the commit stage. It counts instructions issued but not yet committed for each warp and produces the registered `committed_warps` pulse vector that the scheduler consumes through the commit-to-scheduler interface. It also produces per-warp "pending is zero" flags. A single-outstanding drain (fence) handshake lets the scheduler wait until one warp has no instructions in flight.

## Interface
Parameters:
- `NUM_WARPS`, default 4: number of warps tracked; `WID_W = max(1, $clog2(NUM_WARPS))`.
- `NUM_COMMITS`, default 2: number of commit ports retiring per cycle.
- `CTR_WIDTH`, default 5: per-warp counter width; `MAX_PENDING = 2^CTR_WIDTH - 1`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  instruction issue request.
- `issue_wid`  in  WID_W  warp of the issuing instruction.
- `issue_ready`  out  1  combinational; issue accepted when `issue_valid && issue_ready`.
- `commit_valid`  in  NUM_COMMITS  one bit per commit port; each bit retires one instruction.
- `commit_wid`  in  NUM_COMMITS*WID_W  warp id per port, port i at bits [i*WID_W +: WID_W].
- `committed_warps`  out  NUM_WARPS  registered; bit w pulses the cycle after any commit for warp w.
- `pending_zero`  out  NUM_WARPS  registered; bit w = (count[w] == 0).
- `drain_valid`  in  1  drain request.
- `drain_wid`  in  WID_W  warp to drain.
- `drain_ready`  out  1  combinational; equals (state == IDLE) and !reset.
- `drain_done`  out  1  registered; one-cycle pulse when the drain completes.
- `drain_done_wid`  out  WID_W  warp of the completed drain; valid while `drain_done` is high.
- `underflow_err`  out  1  sticky error flag.

## Operation
- Counters `count[w]` are CTR_WIDTH wide.
- `inc[w]` = issue fire with `issue_wid == w`.
- `dec[w]` = number of ports i with `commit_valid[i] && commit_wid[i] == w` (range 0..NUM_COMMITS).
- Next count: `count[w] + inc[w] - dec[w]`, evaluated in CTR_WIDTH+2 bits.
  - If the result is negative, count clamps to 0 and `underflow_err` sets. It stays set until reset.
- `issue_ready = (count[issue_wid] != MAX_PENDING) && !(state != IDLE && issue_wid == drain_wid_q)`.
  - Same-cycle commits do not relax the saturation check.
- `committed_warps[w]` next = (`dec[w] != 0`). This includes underflowing commits.
- `pending_zero[w]` next = (next count == 0).
- Drain FSM states:
  - IDLE: `drain_ready = 1`. On `drain_valid`, latch `drain_wid_q` and go to WAIT.
  - WAIT: issue for `drain_wid_q` is blocked. When registered `pending_zero[drain_wid_q]` is 1, go to DONE.
  - DONE: `drain_done = 1`, `drain_done_wid = drain_wid_q`, issue for `drain_wid_q` still blocked. Go to IDLE next cycle.
- An issue for `drain_wid` that fires in the same cycle the drain is accepted is counted. The drain then waits for that instruction to commit.
- A commit for any warp is accepted in every state. Commits are never back-pressured.

## Timing
- Reset values:
  - all `count` = 0, `committed_warps` = 0, `pending_zero` = all 1.
  - state = IDLE, `drain_done` = 0, `drain_done_wid` = 0, `underflow_err` = 0.
  - `drain_ready` = 0 while reset is high.
- Reset mid-drain returns the FSM to IDLE with no `drain_done` pulse.
- Issue or commit at edge N: count updates at edge N. `pending_zero` and `committed_warps` reflect it in cycle N+1.
- Drain accepted at edge N with count already 0: WAIT in cycle N+1, DONE (`drain_done` = 1) in cycle N+2.
- Drain with outstanding work: `drain_done` asserts 2 cycles after the edge that brings the count to 0.
- `committed_warps` bits are single-cycle pulses. Back-to-back commits for a warp keep the bit high on consecutive cycles.
- Simultaneous issue and commit for one warp leave the count unchanged. `committed_warps[w]` still pulses.

## Test plan
- Reset, then issue warp 2 three times, then commit warp 2 on ports 0 and 1 in the same cycle -> count[2] goes 3 then 1; `committed_warps` = 4'b0100 for one cycle; `pending_zero[2]` = 0.
- Issue warp 1 until the count reaches 31 (CTR_WIDTH = 5) -> `issue_ready` = 0 for warp 1 and 1 for warp 0; one commit on warp 1 restores `issue_ready` the next cycle.
- Drain warp 0 with count 0, accepted at cycle 10 -> `drain_done` = 1 with `drain_done_wid` = 0 at cycle 12; `drain_ready` = 0 in cycles 11-12.
- Drain warp 3 with 2 pending -> issue for warp 3 is blocked while issue for warp 1 proceeds; `drain_done` arrives 2 cycles after the second commit; a second `drain_valid` during WAIT is not accepted.
- Commit warp 1 with count 0 -> count stays 0, `underflow_err` = 1 and stays set until reset; `committed_warps[1]` pulses.
- Assert reset during WAIT -> next cycle state is IDLE, all counts 0, `pending_zero` = all 1, and no `drain_done` pulse.
